// File: rtl/dmem_initiator.sv
// Core-side initiator for a handshaked, variable-latency data memory.
// Turns LW/SW into req/ack transactions, stalls the core while busy and forms the write-back word.
module dmem_initiator #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              InsValid,
    input  logic [31:0]       Ins,
    input  logic [DATA_W-1:0] Result,
    input  logic [DATA_W-1:0] Rdata2,
    input  logic [DATA_W-1:0] nextPC,
    output logic              Stall,
    output logic [DATA_W-1:0] Wdata,
    output logic              WdataValid,
    output logic              MemReq,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRdata,
    output logic              MemTimeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [5:0]  OP_RTYPE   = 6'h00;
    localparam logic [5:0]  OP_JAL     = 6'h03;
    localparam logic [5:0]  OP_LW      = 6'h23;
    localparam logic [5:0]  OP_SW      = 6'h2B;
    localparam logic [5:0]  FUNCT_JALR = 6'h09;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic [DATA_W-1:0] addr_nxt, wdata_nxt;
    logic              we_nxt, req_nxt, tout_nxt;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_mem;
    logic       is_link;
    logic       unused_ins;

    assign opcode     = Ins[31:26];
    assign funct      = Ins[5:0];
    assign unused_ins = ^Ins[25:6];
    assign is_mem     = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_link    = (opcode == OP_JAL) || ((opcode == OP_RTYPE) && (funct == FUNCT_JALR));
    assign cnt_inc    = cnt + CNT_W'(1);

    // State and registered datapath; reset clears everything, including an in-flight request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata_q    <= '0;
            MemReq     <= 1'b0;
            MemWe      <= 1'b0;
            MemAddr    <= '0;
            MemWdata   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rdata_q    <= rdata_nxt;
            MemReq     <= req_nxt;
            MemWe      <= we_nxt;
            MemAddr    <= addr_nxt;
            MemWdata   <= wdata_nxt;
            MemTimeout <= tout_nxt;
        end
    end

    // Next-state, register updates and the combinational core-facing outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rdata_nxt  = rdata_q;
        req_nxt    = MemReq;
        we_nxt     = MemWe;
        addr_nxt   = MemAddr;
        wdata_nxt  = MemWdata;
        tout_nxt   = MemTimeout;
        Stall      = 1'b0;
        Wdata      = Result;
        WdataValid = 1'b0;

        case (state)
            IDLE: begin
                if (InsValid && is_mem) begin
                    addr_nxt  = Result;
                    wdata_nxt = Rdata2;
                    we_nxt    = (opcode == OP_SW);
                    cnt_nxt   = '0;
                    req_nxt   = 1'b1;
                    Stall     = 1'b1;
                    state_nxt = REQ;
                end else begin
                    Wdata      = is_link ? nextPC : Result;
                    WdataValid = InsValid;
                end
            end
            REQ: begin
                Stall = 1'b1;
                // An ack landing on the final allowed cycle still counts as success.
                if (MemAck) begin
                    if (!MemWe) begin
                        rdata_nxt = MemRdata;
                    end
                    req_nxt   = 1'b0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        tout_nxt  = 1'b1;
                        rdata_nxt = '0;
                        req_nxt   = 1'b0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                WdataValid = InsValid;
                Wdata      = MemWe ? Result : rdata_q;
                state_nxt  = IDLE;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// Self-checking bench for dmem_initiator: directed scenarios plus randomized traffic
// checked against a transaction-level model (memory array, ack delay, sticky timeout).
module tb_dmem_initiator;

    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          InsValid = 1'b0;
    logic [31:0]   Ins = '0;
    logic [DW-1:0] Result = '0, Rdata2 = '0, nextPC = '0;
    logic          Stall, WdataValid, MemReq, MemWe, MemTimeout;
    logic [DW-1:0] Wdata, MemAddr, MemWdata;
    logic          MemAck = 1'b0;
    logic [DW-1:0] MemRdata = '0;

    int checks = 0;
    int passes = 0;
    bit exp_tmo = 1'b0;
    logic [31:0] mem [logic [31:0]];

    dmem_initiator #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins), .Result(Result),
        .Rdata2(Rdata2), .nextPC(nextPC), .Stall(Stall), .Wdata(Wdata),
        .WdataValid(WdataValid), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWdata(MemWdata), .MemAck(MemAck), .MemRdata(MemRdata), .MemTimeout(MemTimeout)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        #1;
        checks++; if ({MemReq, MemWe, MemTimeout, Stall, WdataValid} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {MemReq, MemWe, MemTimeout, Stall, WdataValid}); else passes++;
        checks++; if ({MemAddr, MemWdata} !== 64'h0) $display("FAIL reset_bus got %h want 0", {MemAddr, MemWdata}); else passes++;
        @(negedge CLK); RST = 1'b0;
    endtask

    // Non-memory instruction: zero-latency write-back, no traffic.
    task automatic test_alu(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] res, input logic [31:0] npc);
        logic [31:0] exp_w;
        exp_w = (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) ? npc : res;
        @(posedge CLK); #1;
        InsValid = 1'b1; Ins = {op, 20'($urandom), fn}; Result = res; Nextpc_set(npc);
        Rdata2 = $urandom; MemAck = 1'($urandom);
        #4;
        checks++; if (Wdata !== exp_w) $display("FAIL alu_wdata got %h want %h", Wdata, exp_w); else passes++;
        checks++; if ({WdataValid, Stall, MemReq} !== 3'b100) $display("FAIL alu_flags got %b want 100", {WdataValid, Stall, MemReq}); else passes++;
    endtask

    task automatic Nextpc_set(input logic [31:0] v);
        nextPC = v;
    endtask

    // One LW/SW with the responder acking on REQ cycle d (0-based); d >= TMO never acks.
    task automatic test_mem_op(input bit is_sw, input logic [31:0] addr, input logic [31:0] data, input int d);
        int reqs; bit tout; logic [31:0] rd, exp_w;
        if (!is_sw && !mem.exists(addr)) mem[addr] = $urandom;
        rd    = is_sw ? 32'h0 : mem[addr];
        tout  = (d >= int'(TMO));
        reqs  = tout ? int'(TMO) : d + 1;
        exp_w = is_sw ? addr : (tout ? 32'h0 : rd);

        @(posedge CLK); #1;
        InsValid = 1'b1; Ins = {is_sw ? OP_SW : OP_LW, 26'($urandom)};
        Result = addr; Rdata2 = data; nextPC = $urandom; MemAck = 1'b0; MemRdata = $urandom;
        #4;
        checks++; if ({Stall, MemReq, WdataValid} !== 3'b100) $display("FAIL accept_flags got %b want 100", {Stall, MemReq, WdataValid}); else passes++;

        for (int k = 0; k < reqs; k++) begin
            @(posedge CLK); #1;
            MemAck = (k == d); MemRdata = is_sw ? $urandom : rd;
            #4;
            checks++; if ({MemReq, Stall, MemWe} !== {2'b11, is_sw}) $display("FAIL req_flags cyc %0d got %b want %b", k, {MemReq, Stall, MemWe}, {2'b11, is_sw}); else passes++;
            checks++; if ({MemAddr, MemWdata} !== {addr, data}) $display("FAIL req_bus cyc %0d got %h want %h", k, {MemAddr, MemWdata}, {addr, data}); else passes++;
        end

        @(posedge CLK); #1;
        MemAck = 1'($urandom); MemRdata = $urandom;
        if (tout) exp_tmo = 1'b1;
        if (is_sw && !tout) mem[addr] = data;
        #4;
        checks++; if ({MemReq, Stall, WdataValid} !== 3'b001) $display("FAIL done_flags got %b want 001", {MemReq, Stall, WdataValid}); else passes++;
        checks++; if (Wdata !== exp_w) $display("FAIL done_wdata got %h want %h", Wdata, exp_w); else passes++;
        checks++; if (MemTimeout !== exp_tmo) $display("FAIL timeout_flag got %b want %b", MemTimeout, exp_tmo); else passes++;

        @(posedge CLK); #1;
        InsValid = 1'b0; MemAck = 1'b1;
        #4;
        checks++; if ({MemReq, Stall, WdataValid} !== 3'b000) $display("FAIL post_idle got %b want 000", {MemReq, Stall, WdataValid}); else passes++;
        MemAck = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge CLK); #1;
        InsValid = 1'b1; Ins = {OP_LW, 26'h0}; Result = 32'h7; Rdata2 = '0; MemAck = 1'b0;
        @(posedge CLK); #2;
        checks++; if (MemReq !== 1'b1) $display("FAIL rst_mid_pre got %b want 1", MemReq); else passes++;
        RST = 1'b1; InsValid = 1'b0;
        #1;
        exp_tmo = 1'b0;
        checks++; if ({MemReq, Stall, MemTimeout} !== 3'b000) $display("FAIL rst_mid_drop got %b want 000", {MemReq, Stall, MemTimeout}); else passes++;
        @(posedge CLK); #1;
        RST = 1'b0; MemAck = 1'b1; MemRdata = 32'hBAD0BAD0;
        #4;
        checks++; if ({MemReq, Stall, WdataValid} !== 3'b000) $display("FAIL rst_late_ack got %b want 000", {MemReq, Stall, WdataValid}); else passes++;
        @(posedge CLK); #1;
        MemAck = 1'b0;
        #4;
        checks++; if ({MemReq, MemTimeout} !== 2'b00) $display("FAIL rst_after got %b want 00", {MemReq, MemTimeout}); else passes++;
        test_mem_op(1'b0, 32'h4, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do op = 6'($urandom_range(0, 7) == 0 ? 6'h00 : $urandom); while (op == OP_LW || op == OP_SW);
                test_alu($urandom_range(0, 1) == 1 ? op : 6'h03 & {6{op[0]}}, $urandom_range(0, 1) == 1 ? 6'h09 : 6'($urandom), $urandom, $urandom);
            end else begin
                test_mem_op(1'($urandom), 32'($urandom_range(0, 7)), $urandom, $urandom_range(0, TMO - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu(6'h00, 6'h20, 32'h5, 32'h100);
        test_alu(6'h00, 6'h09, 32'h99, 32'h40);
        test_alu(6'h03, 6'h00, 32'h11, 32'h80);
        test_mem_op(1'b1, 32'h4, 32'hDEAD, 1);
        test_mem_op(1'b0, 32'h4, 32'h0, 0);
        test_mem_op(1'b0, 32'h4, 32'h0, TMO - 1);
        test_mem_op(1'b0, 32'h5, 32'h0, 1000);
        test_mem_op(1'b1, 32'h6, 32'h1234, 2);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
